des_job_arbiter: RTL and testbench

Arbitrates a single iterative DES cipher core between two independent requesters (port 0: SPI host path, port 1: auxiliary/internal path). Accepts one 64-bit block at a time via valid/ready, issues a start pulse to the core, waits for the core's done pulse (with a watchdog), and returns the result to the owning requester via valid/ready. Sits between the SPI front end and the cipher state machine in the top level; the key is configured elsewhere and is not handled here.

---
 rtl/des_job_arbiter.sv | 124 ++++++++++++
 tb/tb_des_job_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_job_arbiter.sv
// Two-port job arbiter in front of a single iterative DES core: round-robin
// grant, one block in flight, watchdog on the core's done pulse.
module des_job_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_data,
    input  logic        req0_decrypt,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_data,
    input  logic        req1_decrypt,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [63:0] rsp0_data,
    output logic        rsp0_err,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [63:0] rsp1_data,
    output logic        rsp1_err,
    output logic        core_start,
    output logic [63:0] core_data_in,
    output logic        core_decrypt,
    input  logic        core_done,
    input  logic [63:0] core_data_out,
    output logic        busy,
    output logic        last_grant
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic        owner;
    logic        grant;
    logic        take;
    logic        rsp_taken;
    logic        timeout_hit;
    logic [15:0] cnt;
    logic [63:0] result;
    logic        err_q;

    assign timeout_hit = (cnt == CNT_LAST);
    assign rsp_taken   = owner ? rsp1_ready : rsp0_ready;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        take       = 1'b0;
        case (state)
            IDLE: begin
                // Ready is gated by rst so the port stays quiet while held in reset.
                req0_ready = !rst && req0_valid && !grant;
                req1_ready = !rst && req1_valid && grant;
                take       = req0_ready || req1_ready;
                if (take) state_nxt = ISSUE;
            end
            ISSUE: state_nxt = WAIT;
            WAIT:  if (core_done || timeout_hit) state_nxt = RESP;
            RESP:  if (rsp_taken) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            core_start   <= 1'b0;
            busy         <= 1'b0;
            rsp0_valid   <= 1'b0;
            rsp1_valid   <= 1'b0;
            core_data_in <= '0;
            core_decrypt <= 1'b0;
            result       <= '0;
            err_q        <= 1'b0;
            cnt          <= '0;
        end else begin
            state      <= state_nxt;
            core_start <= take;
            busy       <= (state_nxt != IDLE);
            rsp0_valid <= (state_nxt == RESP) && !owner;
            rsp1_valid <= (state_nxt == RESP) && owner;
            if (take) begin
                owner        <= grant;
                core_data_in <= grant ? req1_data : req0_data;
                core_decrypt <= grant ? req1_decrypt : req0_decrypt;
            end
            case (state)
                ISSUE: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + 16'd1;
                    // A done arriving on the watchdog's last cycle still wins.
                    if (core_done) begin
                        result <= core_data_out;
                        err_q  <= 1'b0;
                    end else if (timeout_hit) begin
                        result <= '0;
                        err_q  <= 1'b1;
                    end
                end
                RESP: if (rsp_taken) last_grant <= owner;
                default: ;
            endcase
        end
    end

    assign rsp0_data = result;
    assign rsp1_data = result;
    assign rsp0_err  = err_q && rsp0_valid;
    assign rsp1_err  = err_q && rsp1_valid;

endmodule

// File: tb/tb_des_job_arbiter.sv
// Self-checking bench for des_job_arbiter: timestamp-based reference model,
// a known-answer stub cipher core, and directed scenarios.
module tb_des_job_arbiter;

    localparam int TO = 8;
    localparam logic [63:0] PT = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT = 64'h85E813540F0AB405;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [63:0] req0_data = '0, req1_data = '0;
    logic        req0_decrypt = 1'b0, req1_decrypt = 1'b0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [63:0] rsp0_data, rsp1_data;
    logic        rsp0_err, rsp1_err;
    logic        core_start;
    logic [63:0] core_data_in;
    logic        core_decrypt;
    logic        core_done = 1'b0;
    logic [63:0] core_data_out = '0;
    logic        busy, last_grant;

    des_job_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_decrypt(req0_decrypt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_decrypt(req1_decrypt),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
        .core_start(core_start), .core_data_in(core_data_in), .core_decrypt(core_decrypt),
        .core_done(core_done), .core_data_out(core_data_out),
        .busy(busy), .last_grant(last_grant)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Known-answer stub: the FIPS example vector in both directions, a
    // recognisable scramble otherwise.
    function automatic logic [63:0] stub_cipher(input logic [63:0] d, input logic dec);
        if (!dec && d == PT) return CT;
        if (dec && d == CT) return PT;
        return {d[31:0], d[63:32]} ^ {64{dec}};
    endfunction

    int stub_lat = 3;        // cycles from the start pulse to done; <= 0 means never
    int force_done_cyc = -1; // cycle on which a stray done pulse is injected

    initial begin : stub_core
        int cd;
        cd = 0;
        forever begin
            @(posedge clk); #1;
            core_done = 1'b0;
            if (rst) cd = 0;
            else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        core_done     = 1'b1;
                        core_data_out = stub_cipher(core_data_in, core_decrypt);
                    end
                end
                if (core_start && stub_lat > 0) cd = stub_lat;
                if (cyc == force_done_cyc) begin
                    core_done     = 1'b1;
                    core_data_out = 64'hDEADBEEFDEADBEEF;
                end
            end
        end
    end

    // Reference model: a job is described by its accept cycle and the cycle its
    // response becomes visible; outputs follow from those timestamps.
    bit          m_busy, m_owner, m_dec, m_err, m_last, g, er0, er1, ev0, ev1, in_resp;
    int          m_acc, m_resp;
    logic [63:0] m_cdata, m_res;
    int          n_starts = 0;
    int          n_rsp0 = 0;
    int          grants[$];

    initial begin : model
        forever begin
            @(negedge clk);
            if (rst) begin
                m_busy = 0; m_owner = 0; m_last = 1; m_cdata = '0; m_dec = 0;
                m_res = '0; m_err = 0; m_acc = -10; m_resp = -1;
            end
            g       = (req0_valid && req1_valid) ? !m_last : req1_valid;
            er0     = !rst && !m_busy && req0_valid && !g;
            er1     = !rst && !m_busy && req1_valid && g;
            in_resp = m_busy && m_resp >= 0 && cyc >= m_resp;
            ev0     = in_resp && !m_owner;
            ev1     = in_resp && m_owner;
            check("cmp_req0_ready", req0_ready, er0);
            check("cmp_req1_ready", req1_ready, er1);
            check("cmp_busy", busy, m_busy);
            check("cmp_core_start", core_start, m_busy && cyc == m_acc + 1);
            check("cmp_rsp0_valid", rsp0_valid, ev0);
            check("cmp_rsp1_valid", rsp1_valid, ev1);
            check("cmp_rsp0_err", rsp0_err, ev0 && m_err);
            check("cmp_rsp1_err", rsp1_err, ev1 && m_err);
            check("cmp_last_grant", last_grant, m_last);
            check("cmp_core_data_in", core_data_in, m_cdata);
            check("cmp_core_decrypt", core_decrypt, m_dec);
            if (ev0) check("cmp_rsp0_data", rsp0_data, m_res);
            if (ev1) check("cmp_rsp1_data", rsp1_data, m_res);

            if (core_start) n_starts++;
            if (rsp0_valid) n_rsp0++;
            if (req0_valid && req0_ready) grants.push_back(0);
            if (req1_valid && req1_ready) grants.push_back(1);

            if (!rst) begin
                if (m_busy) begin
                    if (m_resp < 0 && cyc >= m_acc + 2) begin
                        if (core_done) begin
                            m_res = core_data_out; m_err = 0; m_resp = cyc + 1;
                        end else if (cyc == m_acc + 1 + TO) begin
                            m_res = '0; m_err = 1; m_resp = cyc + 1;
                        end
                    end else if (in_resp && (m_owner ? rsp1_ready : rsp0_ready)) begin
                        m_busy = 0; m_last = m_owner;
                    end
                end else if (er0 || er1) begin
                    m_busy  = 1; m_owner = g; m_acc = cyc; m_resp = -1;
                    m_cdata = g ? req1_data : req0_data;
                    m_dec   = g ? req1_decrypt : req0_decrypt;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input bit port, input logic [63:0] d, input bit dec, output int hs);
        @(posedge clk); #1;
        if (port) begin req1_valid = 1; req1_data = d; req1_decrypt = dec; end
        else      begin req0_valid = 1; req0_data = d; req0_decrypt = dec; end
        hs = -1;
        for (int i = 0; i < 200 && hs < 0; i++) begin
            @(negedge clk); #1;
            if (port ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) hs = cyc;
        end
        if (hs < 0) check("send_accept_bound", 64'd0, 64'd1);
        @(posedge clk); #1;
        if (port) req1_valid = 0; else req0_valid = 0;
    endtask

    task automatic wait_rsp(input bit port, output logic [63:0] d, output logic e, output int rc);
        rc = -1;
        for (int i = 0; i < 200 && rc < 0; i++) begin
            @(negedge clk); #1;
            if (port ? rsp1_valid : rsp0_valid) begin
                rc = cyc;
                d  = port ? rsp1_data : rsp0_data;
                e  = port ? rsp1_err : rsp0_err;
            end
        end
        if (rc < 0) begin
            check("rsp_wait_bound", 64'd0, 64'd1);
            d = 'x; e = 1'bx;
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int hs, rc, s0, r0, g0, h0, h1;
        logic [63:0] d;
        logic e;

        repeat (3) tick();
        check("reset_busy", busy, 0);
        check("reset_last_grant", last_grant, 1);
        check("reset_core_data_in", core_data_in, 0);
        rst = 0;
        tick();

        // Single encrypt job on port 0.
        stub_lat = 3; s0 = n_starts;
        send(0, PT, 0, hs);
        wait_rsp(0, d, e, rc);
        check("t1_data", d, CT);
        check("t1_err", e, 0);
        check("t1_latency", rc - hs, 5);
        tick(); tick();
        check("t1_starts", n_starts - s0, 1);
        check("t1_last_grant", last_grant, 0);

        // Decrypt round trip on port 1.
        r0 = n_rsp0;
        send(1, CT, 1, hs);
        wait_rsp(1, d, e, rc);
        check("t2_data", d, PT);
        check("t2_err", e, 0);
        tick(); tick();
        check("t2_no_rsp0", n_rsp0 - r0, 0);
        check("t2_last_grant", last_grant, 1);

        // Contention: both ports keep requesting; done after 6 cycles keeps
        // each job inside the 8-cycle watchdog.
        stub_lat = 6; g0 = grants.size(); s0 = n_starts;
        fork
            begin
                for (int i = 0; i < 4; i++) send(0, 64'h1000 + i, 0, h0);
            end
            begin
                for (int i = 0; i < 4; i++) send(1, 64'h2000 + i, 1, h1);
            end
        join
        repeat (20) tick();
        check("t3_grant_count", grants.size() - g0, 8);
        for (int i = 0; i < 8; i++)
            if (g0 + i < grants.size()) check("t3_grant_order", grants[g0 + i], i % 2);
        check("t3_starts", n_starts - s0, 8);

        // Watchdog: core never answers.
        stub_lat = -1;
        send(0, 64'hCAFEF00DCAFEF00D, 0, hs);
        wait_rsp(0, d, e, rc);
        check("t4_timeout_latency", rc - hs, 10);
        check("t4_err", e, 1);
        check("t4_data", d, 0);
        stub_lat = 3;
        send(0, PT, 0, hs);
        wait_rsp(0, d, e, rc);
        check("t4_recover_err", e, 0);
        check("t4_recover_data", d, CT);

        // Backpressure on port 0 with port 1 waiting.
        stub_lat = 2;
        tick(); rsp0_ready = 0;
        send(0, PT, 0, hs);
        wait_rsp(0, d, e, rc);
        tick(); req1_valid = 1; req1_data = CT; req1_decrypt = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            check("t5_rsp0_valid", rsp0_valid, 1);
            check("t5_rsp0_data", rsp0_data, CT);
            check("t5_busy", busy, 1);
            check("t5_req1_ready", req1_ready, 0);
        end
        tick(); rsp0_ready = 1; req1_valid = 0;
        send(1, CT, 1, hs);
        wait_rsp(1, d, e, rc);
        check("t5_port1_data", d, PT);

        // Done on the watchdog's last cycle wins; one cycle later it is too late.
        stub_lat = 8;
        send(0, PT, 0, hs);
        wait_rsp(0, d, e, rc);
        check("t6_race_latency", rc - hs, 10);
        check("t6_race_err", e, 0);
        check("t6_race_data", d, CT);
        stub_lat = 9;
        send(0, PT, 0, hs);
        wait_rsp(0, d, e, rc);
        check("t6_late_err", e, 1);
        check("t6_late_data", d, 0);

        // Stray done while idle.
        tick(); force_done_cyc = cyc + 2;
        repeat (5) tick();
        check("t7_busy", busy, 0);
        check("t7_rsp0_valid", rsp0_valid, 0);
        check("t7_last_grant", last_grant, 0);

        // Asynchronous reset in the middle of WAIT.
        stub_lat = -1;
        send(1, PT, 1, hs);
        repeat (3) tick();
        check("t8_pre_busy", busy, 1);
        @(negedge clk); #2;
        rst = 1;
        #1;
        check("t8_busy", busy, 0);
        check("t8_rsp1_valid", rsp1_valid, 0);
        check("t8_core_data_in", core_data_in, 0);
        check("t8_core_decrypt", core_decrypt, 0);
        check("t8_last_grant", last_grant, 1);
        repeat (2) tick();
        rst = 0;
        stub_lat = 3; g0 = grants.size();
        fork
            send(0, PT, 0, h0);
            send(1, CT, 1, h1);
        join
        repeat (15) tick();
        check("t8_grant_count", grants.size() - g0, 2);
        if (g0 < grants.size()) check("t8_first_grant", grants[g0], 0);

        repeat (5) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
